regfile_writeback: RTL and testbench



---
 rtl/regfile_writeback.sv | 167 ++++++++++++++++
 tb/tb_regfile_writeback.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order write-back buffer in front of the single write
// port of the 32x32 register file. ALU and load results are queued in a
// circular FIFO and drained one per cycle onto regWrite/writeReg/writeData.
// Optional feature macro: WB_BYPASS_EN adds the rs/rt lookup of queued values.

`ifdef WB_BYPASS_EN
// Per-slot compare: is this slot live, and does it hold rs / rt?
module regfile_writeback_slot #(
   parameter int DEPTH = 4,
   parameter int SLOT  = 0
) (
   input  logic [$clog2(DEPTH)-1:0] headPtr,
   input  logic [$clog2(DEPTH):0]   count,
   input  logic [4:0]               slotDst,
   input  logic [4:0]               rs,
   input  logic [4:0]               rt,
   output logic                     rsMatch,
   output logic                     rtMatch
);
   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] age;
   logic          live;

   // A slot is live when its distance from head is below the occupancy.
   always_comb begin
      age     = PW'(SLOT) - headPtr;
      live    = {1'b0, age} < count;
      rsMatch = live && (rs != 5'd0) && (slotDst == rs);
      rtMatch = live && (rt != 5'd0) && (slotDst == rt);
   end
endmodule
`endif

module regfile_writeback #(
   parameter int DEPTH = 4   // power of two, >= 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [4:0]  alu_reg,
   input  logic [31:0] alu_data,
   input  logic        mem_valid,
   input  logic [4:0]  mem_reg,
   input  logic [31:0] mem_data,
   output logic        in_ready,
   output logic        regWrite,
   output logic [4:0]  writeReg,
   output logic [31:0] writeData
`ifdef WB_BYPASS_EN
   ,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   output logic        rs_hit,
   output logic        rt_hit,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [4:0]  dst;
      logic [31:0] data;
   } wbEntry_t;

   wbEntry_t      fifoMem [DEPTH];
   logic [PW-1:0] headPtr;
   logic [PW-1:0] tailPtr;
   logic [CW-1:0] count;

   logic [CW-1:0] freeSlots;
   logic          pushMem;
   logic          pushAlu;
   logic [CW-1:0] pushCount;
   logic          pop;
   logic [PW-1:0] memSlot;
   logic [PW-1:0] aluSlot;
   wbEntry_t      headEntry;

   // Accept/drain decisions. in_ready looks at count only, so a same-cycle
   // pop never earns extra room. r0 results are handshaken but dropped.
   always_comb begin
      freeSlots = CW'(DEPTH) - count;
      in_ready  = freeSlots >= CW'(2);
      pushMem   = mem_valid && in_ready && (mem_reg != 5'd0);
      pushAlu   = alu_valid && in_ready && (alu_reg != 5'd0);
      pushCount = CW'(pushMem) + CW'(pushAlu);
      pop       = (count != '0);
      // The load result is older, so it takes the first free slot.
      memSlot   = tailPtr;
      aluSlot   = tailPtr + PW'(pushMem);
   end

   // Entry storage; contents need no reset because count gates every use.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (pushMem) fifoMem[memSlot] <= '{dst: mem_reg, data: mem_data};
         if (pushAlu) fifoMem[aluSlot] <= '{dst: alu_reg, data: alu_data};
      end
   end

   // Pointer and occupancy update; head pops whenever anything is queued.
   always_ff @(posedge clk) begin
      if (rst) begin
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
      end else begin
         headPtr <= headPtr + PW'(pop);
         tailPtr <= tailPtr + PW'(pushCount);
         count   <= count + pushCount - CW'(pop);
      end
   end

   // Write port driven straight from the head entry. Held low during reset
   // so entries being flushed never reach the register file.
   always_comb begin
      headEntry = fifoMem[headPtr];
      regWrite  = pop && !rst;
      writeReg  = regWrite ? headEntry.dst  : 5'd0;
      writeData = regWrite ? headEntry.data : 32'd0;
   end

`ifdef WB_BYPASS_EN
   logic [DEPTH-1:0] rsMatchVec;
   logic [DEPTH-1:0] rtMatchVec;
   logic [PW-1:0]    scanIdx;

   for (genvar g = 0; g < DEPTH; g++) begin : gSlot
      regfile_writeback_slot #(
         .DEPTH (DEPTH),
         .SLOT  (g)
      ) uSlot (
         .headPtr (headPtr),
         .count   (count),
         .slotDst (fifoMem[g].dst),
         .rs      (rs),
         .rt      (rt),
         .rsMatch (rsMatchVec[g]),
         .rtMatch (rtMatchVec[g])
      );
   end

   // Walk slots oldest to youngest so the last match (closest to tail) wins.
   always_comb begin
      rs_hit  = 1'b0;
      rt_hit  = 1'b0;
      rs_data = 32'd0;
      rt_data = 32'd0;
      scanIdx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         scanIdx = headPtr + PW'(k);
         if (rsMatchVec[scanIdx]) begin
            rs_hit  = 1'b1;
            rs_data = fifoMem[scanIdx].data;
         end
         if (rtMatchVec[scanIdx]) begin
            rt_hit  = 1'b1;
            rt_data = fifoMem[scanIdx].data;
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset state, single and dual
// accepts, back-pressure with pointer wrap, r0 discard, reset mid-drain.
// Bypass checks are compiled in only when WB_BYPASS_EN is defined.
module tb_regfile_writeback;
   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_reg;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic [4:0]  mem_reg;
   logic [31:0] mem_data;
   logic        in_ready;
   logic        regWrite;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
`ifdef WB_BYPASS_EN
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        rs_hit;
   logic        rt_hit;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
`endif

   int checks   = 0;
   int failures = 0;
   int base;
   logic [36:0] commitLog [$];

   regfile_writeback #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_reg   (alu_reg),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_reg   (mem_reg),
      .mem_data  (mem_data),
      .in_ready  (in_ready),
      .regWrite  (regWrite),
      .writeReg  (writeReg),
      .writeData (writeData)
`ifdef WB_BYPASS_EN
      ,
      .rs        (rs),
      .rt        (rt),
      .rs_hit    (rs_hit),
      .rt_hit    (rt_hit),
      .rs_data   (rs_data),
      .rt_data   (rt_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file side: record every write the port performs.
   always @(posedge clk) begin
      if (regWrite === 1'b1) commitLog.push_back({writeReg, writeData});
   end

   task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Register file contents as seen by a reader: last logged write, else 0.
   function automatic logic [31:0] rfRead(input logic [4:0] r);
      logic [31:0] v;
      v = 32'd0;
      foreach (commitLog[i]) if (commitLog[i][36:32] == r) v = commitLog[i][31:0];
      return v;
   endfunction

   task automatic drive(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad);
      mem_valid = mv; mem_reg = mr; mem_data = md;
      alu_valid = av; alu_reg = ar; alu_data = ad;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifdef WB_BYPASS_EN
      rs = 5'd0; rt = 5'd0;
`endif
      tick();
      tick();
      rst = 1'b0;
      chk("rst_regWrite", 37'(regWrite), 37'd0);
      chk("rst_in_ready", 37'(in_ready), 37'd1);
      chk("rst_writeReg", 37'(writeReg), 37'd0);
      chk("rst_writeData", 37'(writeData), 37'd0);
`ifdef WB_BYPASS_EN
      rs = 5'd21; rt = 5'd5;
      chk("rst_hits", 37'({rs_hit, rt_hit}), 37'd0);
`endif

      // Single ALU result, empty buffer: on the port the next cycle only.
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'd45);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("s1_regWrite", 37'(regWrite), 37'd1);
      chk("s1_port", {writeReg, writeData}, {5'd21, 32'd45});
      tick();
      chk("s1_drained", 37'(regWrite), 37'd0);
      chk("s1_rf21", 37'(rfRead(5'd21)), 37'd45);

      // Same-cycle load and ALU to r5: load first, ALU second.
      drive(1'b1, 5'd5, 32'd10, 1'b1, 5'd5, 32'd20);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("s2_first", {writeReg, writeData}, {5'd5, 32'd10});
`ifdef WB_BYPASS_EN
      rs = 5'd5; rt = 5'd3;
      chk("s2_rs_youngest", {4'd0, rs_hit, rs_data}, {4'd0, 1'b1, 32'd20});
      chk("s2_rt_miss", {4'd0, rt_hit, rt_data}, 37'd0);
`endif
      tick();
      chk("s2_second", {writeReg, writeData}, {5'd5, 32'd20});
      tick();
      chk("s2_idle", 37'(regWrite), 37'd0);
      chk("s2_rf5", 37'(rfRead(5'd5)), 37'd20);

      // Back-pressure: both producers busy, ready tracks count 2/3/2/3.
      base = commitLog.size();
      drive(1'b1, 5'd1, 32'd101, 1'b1, 5'd2, 32'd102);
      tick();
      chk("s3_rdy_e1", 37'(in_ready), 37'd1);
      drive(1'b1, 5'd3, 32'd103, 1'b1, 5'd4, 32'd104);
      tick();
      chk("s3_rdy_e2", 37'(in_ready), 37'd0);
      drive(1'b1, 5'd5, 32'd105, 1'b1, 5'd6, 32'd106);
      tick();
      chk("s3_rdy_e3", 37'(in_ready), 37'd1);
      tick();
      chk("s3_rdy_e4", 37'(in_ready), 37'd0);
`ifdef WB_BYPASS_EN
      rs = 5'd4; rt = 5'd2;
      chk("s3_rs_hit", {4'd0, rs_hit, rs_data}, {4'd0, 1'b1, 32'd104});
      chk("s3_rt_committed", {4'd0, rt_hit, rt_data}, 37'd0);
`endif
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      tick();
      tick();
      chk("s3_idle", 37'(regWrite), 37'd0);
      chk("s3_nwrites", 37'(commitLog.size() - base), 37'd6);
      for (int k = 0; k < 6; k++) begin
         if (base + k < commitLog.size())
            chk($sformatf("s3_commit%0d", k), commitLog[base + k], {5'(k + 1), 32'(101 + k)});
         else
            chk($sformatf("s3_commit%0d", k), 37'h1f_ffff_ffff, {5'(k + 1), 32'(101 + k)});
      end

      // ALU to r0 is discarded, load to r7 goes through.
      base = commitLog.size();
      drive(1'b1, 5'd7, 32'd7, 1'b1, 5'd0, 32'd99);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("s4_port", {writeReg, writeData}, {5'd7, 32'd7});
`ifdef WB_BYPASS_EN
      rs = 5'd0; rt = 5'd7;
      chk("s4_rs_r0", {4'd0, rs_hit, rs_data}, 37'd0);
      chk("s4_rt_hit", {4'd0, rt_hit, rt_data}, {4'd0, 1'b1, 32'd7});
`endif
      tick();
      chk("s4_idle", 37'(regWrite), 37'd0);
      chk("s4_nwrites", 37'(commitLog.size() - base), 37'd1);
      drive(1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("s4_both_r0", {3'd0, regWrite, in_ready, 32'd0}, {3'd0, 1'b0, 1'b1, 32'd0});

      // Reset with three entries queued: none of them reaches the file.
      base = commitLog.size();
      drive(1'b1, 5'd8, 32'd81, 1'b1, 5'd9, 32'd91);
      tick();
      drive(1'b1, 5'd10, 32'd82, 1'b1, 5'd11, 32'd92);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("s5_full", 37'(in_ready), 37'd0);
`ifdef WB_BYPASS_EN
      rs = 5'd11; rt = 5'd9;
      chk("s5_rs_hit", {4'd0, rs_hit, rs_data}, {4'd0, 1'b1, 32'd92});
`endif
      rst = 1'b1;
      drive(1'b1, 5'd12, 32'd55, 1'b1, 5'd13, 32'd66);
      #1;
      chk("s5_in_rst_regWrite", 37'(regWrite), 37'd0);
      tick();
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("s5_regWrite", 37'(regWrite), 37'd0);
      chk("s5_in_ready", 37'(in_ready), 37'd1);
      chk("s5_port", {writeReg, writeData}, 37'd0);
`ifdef WB_BYPASS_EN
      chk("s5_hits", {3'd0, rs_hit, rt_hit, rs_data | rt_data}, 37'd0);
`endif
      tick();
      tick();
      tick();
      chk("s5_nwrites", 37'(commitLog.size() - base), 37'd1);
      chk("s5_only_r8", 37'(rfRead(5'd8)), 37'd81);
      chk("s5_r9_r10_r11", {5'd0, rfRead(5'd9) | rfRead(5'd10) | rfRead(5'd11)}, 37'd0);
      chk("s5_r12_r13", {5'd0, rfRead(5'd12) | rfRead(5'd13)}, 37'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
